// File: rtl/vfpu_dutw_bridge_if.sv
// Operand/result bus joining the test side, the DUT-side bridge and the VFPU core.
// The bridge takes the slave modport; the test side and the core model take the master modport.
interface vfpu_dutw_bridge_if #(
  parameter int DW = 32
);
  // Test side: operands qualified by op_vld, results qualified by res_rdy.
  logic          op_vld;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic [DW-1:0] operand_c;
  logic [DW-1:0] res;
  logic          res_rdy;

  // Core side.
  logic          core_op_vld;
  logic          core_op_rdy;
  logic [DW-1:0] core_operand_a;
  logic [DW-1:0] core_operand_b;
  logic [DW-1:0] core_operand_c;
  logic          core_res_vld;
  logic [DW-1:0] core_res;

  modport slave (
    input  op_vld, operand_a, operand_b, operand_c,
    input  core_op_rdy, core_res_vld, core_res,
    output res, res_rdy,
    output core_op_vld, core_operand_a, core_operand_b, core_operand_c
  );

  modport master (
    output op_vld, operand_a, operand_b, operand_c,
    output core_op_rdy, core_res_vld, core_res,
    input  res, res_rdy,
    input  core_op_vld, core_operand_a, core_operand_b, core_operand_c
  );
endinterface

// File: rtl/vfpu_dutw_bridge.sv
// DUT-side bridge: buffers operand triples, issues them to the VFPU core under a credit limit
// and returns core results as res/res_rdy. Optional statistics ports: VFPU_BRIDGE_STAT_EN.
module vfpu_dutw_bridge #(
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_OUT    = 4
) (
  input  logic               clk,
  input  logic               rst,
  vfpu_dutw_bridge_if.slave  bus,
  output logic               ovf_err,
  output logic               proto_err,
  output logic               busy
`ifdef VFPU_BRIDGE_STAT_EN
  ,
  output logic [15:0]        ops_in_cnt,
  output logic [15:0]        ops_out_cnt,
  output logic [15:0]        drop_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int IW = $clog2(MAX_OUT + 1);
  localparam logic [IW-1:0] MAX_CNT = IW'(MAX_OUT);

  logic [3*DW-1:0] mem [FIFO_DEPTH];
  logic [3*DW-1:0] head;
  logic [PW-1:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [IW-1:0]   inflight, inflight_nxt;
  logic            empty, full, credit_ok;
  logic            issue, push_ok, drop, res_orphan;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign credit_ok = (inflight < MAX_CNT);

  // Core handshake: a triple transfers on a clock edge where core_op_vld and core_op_rdy are
  // both high. While core_op_vld is high and core_op_rdy low the offered head does not change,
  // and core_op_vld cannot drop because no issue consumes a credit. The test side has no
  // backpressure: op_vld is sampled every cycle and a push into a full FIFO that is not popped
  // in the same cycle is lost.
  assign head = mem[rd_ptr[AW-1:0]];
  assign bus.core_op_vld = !empty && credit_ok;
  // Gating with empty keeps the operand outputs at zero out of reset.
  assign {bus.core_operand_a, bus.core_operand_b, bus.core_operand_c} = empty ? '0 : head;

  assign issue      = bus.core_op_vld && bus.core_op_rdy;
  assign push_ok    = bus.op_vld && (!full || issue);
  assign drop       = bus.op_vld && full && !issue;
  assign res_orphan = bus.core_res_vld && (inflight == '0);

  always_comb begin
    wr_ptr_nxt   = push_ok ? wr_ptr + PW'(1) : wr_ptr;
    rd_ptr_nxt   = issue   ? rd_ptr + PW'(1) : rd_ptr;
    inflight_nxt = inflight;
    if (issue && !bus.core_res_vld) begin
      inflight_nxt = inflight + IW'(1);
    end else if (!issue && bus.core_res_vld && !res_orphan) begin
      inflight_nxt = inflight - IW'(1);
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= {bus.operand_a, bus.operand_b, bus.operand_c};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= '0;
      busy        <= 1'b0;
      bus.res     <= '0;
      bus.res_rdy <= 1'b0;
      ovf_err     <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      inflight    <= inflight_nxt;
      busy        <= (wr_ptr_nxt != rd_ptr_nxt) || (inflight_nxt != '0);
      bus.res_rdy <= bus.core_res_vld;
      if (bus.core_res_vld) begin
        bus.res <= bus.core_res;
      end
      if (drop) begin
        ovf_err <= 1'b1;
      end
      if (res_orphan) begin
        proto_err <= 1'b1;
      end
    end
  end

`ifdef VFPU_BRIDGE_STAT_EN
  // ops_out_cnt steps on the same edge that raises res_rdy, so both agree cycle for cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_in_cnt  <= '0;
      ops_out_cnt <= '0;
      drop_cnt    <= '0;
    end else begin
      if (push_ok) begin
        ops_in_cnt <= ops_in_cnt + 16'd1;
      end
      if (bus.core_res_vld) begin
        ops_out_cnt <= ops_out_cnt + 16'd1;
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end
`endif

  a_head_stable: assert property (@(posedge clk) disable iff (rst)
    (bus.core_op_vld && !bus.core_op_rdy) |=> (bus.core_op_vld && $stable(head)));

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    inflight <= MAX_CNT);

endmodule

// File: tb/tb_vfpu_dutw_bridge.sv
// Self-checking bench for vfpu_dutw_bridge: scoreboards for issued triples and returned results.
module tb_vfpu_dutw_bridge;
  localparam int DW      = 32;
  localparam int DEPTH   = 8;
  localparam int MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ovf_err, proto_err, busy;
`ifdef VFPU_BRIDGE_STAT_EN
  logic [15:0] ops_in_cnt, ops_out_cnt, drop_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int issued   = 0;
  int returned = 0;
  logic [3*DW-1:0] exp_q[$];
  logic [DW-1:0]   exp_res_q[$];

  vfpu_dutw_bridge_if #(.DW(DW)) bus ();

  vfpu_dutw_bridge #(
    .DW(DW), .FIFO_DEPTH(DEPTH), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .ovf_err(ovf_err),
    .proto_err(proto_err),
    .busy(busy)
`ifdef VFPU_BRIDGE_STAT_EN
    ,
    .ops_in_cnt(ops_in_cnt),
    .ops_out_cnt(ops_out_cnt),
    .drop_cnt(drop_cnt)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitors (sample on negedge) ----------------
  always @(negedge clk) begin : mon_issue
    logic [3*DW-1:0] e;
    logic [3*DW-1:0] got;
    if (!rst && bus.core_op_vld && bus.core_op_rdy) begin
      issued++;
      n_vec++;
      got = {bus.core_operand_a, bus.core_operand_b, bus.core_operand_c};
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL issue_unexpected: got %h, expected no issue", got);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          n_miss++;
          $display("FAIL issue_operands: got %h, expected %h", got, e);
        end
      end
    end
  end

  always @(negedge clk) begin : mon_res
    logic [DW-1:0] e;
    if (!rst && bus.res_rdy) begin
      n_vec++;
      if (exp_res_q.size() == 0) begin
        n_miss++;
        $display("FAIL res_unexpected: got %h, expected no res_rdy", bus.res);
      end else begin
        e = exp_res_q.pop_front();
        if (bus.res !== e) begin
          n_miss++;
          $display("FAIL res_value: got %h, expected %h", bus.res, e);
        end
      end
    end
  end

  // ---------------- driver tasks (drive at posedge+1) ----------------
  task automatic push_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] c, input bit accept);
    bus.op_vld    = 1'b1;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.operand_c = c;
    if (accept) exp_q.push_back({a, b, c});
    @(posedge clk); #1;
    bus.op_vld = 1'b0;
  endtask

  task automatic core_result(input logic [DW-1:0] v);
    bus.core_res_vld = 1'b1;
    bus.core_res     = v;
    exp_res_q.push_back(v);
    returned++;
    @(posedge clk); #1;
    bus.core_res_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic clear_inputs;
    bus.op_vld       = 1'b0;
    bus.operand_a    = '0;
    bus.operand_b    = '0;
    bus.operand_c    = '0;
    bus.core_op_rdy  = 1'b0;
    bus.core_res_vld = 1'b0;
    bus.core_res     = '0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    clear_inputs();
    exp_q.delete();
    exp_res_q.delete();
    issued   = 0;
    returned = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Acts as the core: accepts every offer and returns one result per outstanding op.
  task automatic drain(input int budget);
    int n = 0;
    bus.core_op_rdy = 1'b1;
    while ((exp_q.size() != 0 || issued != returned) && n < budget) begin
      if (issued > returned) core_result(32'hC0DE_0000 + n);
      else idle(1);
      n++;
    end
    idle(2);
    n_vec++;
    if (exp_q.size() != 0 || issued != returned || exp_res_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: pending ops %0d, outstanding %0d, pending res %0d, required 0/0/0",
               exp_q.size(), issued - returned, exp_res_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    idle(2);
    n_vec++;
    if ({bus.res, bus.res_rdy, bus.core_op_vld} !== '0) begin
      n_miss++;
      $display("FAIL reset_res: res=%h res_rdy=%b core_op_vld=%b, required 0",
               bus.res, bus.res_rdy, bus.core_op_vld);
    end
    n_vec++;
    if ({bus.core_operand_a, bus.core_operand_b, bus.core_operand_c} !== '0) begin
      n_miss++;
      $display("FAIL reset_operands: got %h %h %h, required 0",
               bus.core_operand_a, bus.core_operand_b, bus.core_operand_c);
    end
    n_vec++;
    if ({ovf_err, proto_err, busy} !== 3'b000) begin
      n_miss++;
      $display("FAIL reset_flags: ovf=%b proto=%b busy=%b, required 000", ovf_err, proto_err, busy);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_single_op;
    do_reset();
    bus.core_op_rdy = 1'b1;
    push_op(32'h3F80_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
    n_vec++;
    if (bus.core_op_vld !== 1'b1) begin
      n_miss++;
      $display("FAIL single_latency: core_op_vld=%b one cycle after op_vld, required 1", bus.core_op_vld);
    end
    idle(1);
    bus.core_op_rdy = 1'b0;
    core_result(32'h4000_0000);
    n_vec++;
    if (bus.res_rdy !== 1'b1 || bus.res !== 32'h4000_0000) begin
      n_miss++;
      $display("FAIL single_return: res_rdy=%b res=%h, required 1 40000000", bus.res_rdy, bus.res);
    end
    idle(1);
    n_vec++;
    if (bus.res_rdy !== 1'b0 || bus.res !== 32'h4000_0000 || busy !== 1'b0) begin
      n_miss++;
      $display("FAIL single_hold: res_rdy=%b res=%h busy=%b, required 0 40000000 0",
               bus.res_rdy, bus.res, busy);
    end
`ifdef VFPU_BRIDGE_STAT_EN
    n_vec++;
    if (ops_in_cnt !== 16'd1 || ops_out_cnt !== 16'd1) begin
      n_miss++;
      $display("FAIL single_stats: in=%0d out=%0d, required 1 1", ops_in_cnt, ops_out_cnt);
    end
`endif
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++)
      push_op(32'h1000 + i, 32'h2000 + i, 32'h3000 + i, i < DEPTH);
    n_vec++;
    if (ovf_err !== 1'b1 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL ovf_flag: ovf_err=%b busy=%b, required 1 1", ovf_err, busy);
    end
    n_vec++;
    if (bus.core_op_vld !== 1'b1 || bus.core_operand_a !== 32'h1000) begin
      n_miss++;
      $display("FAIL ovf_stall_head: core_op_vld=%b a=%h, required 1 00001000",
               bus.core_op_vld, bus.core_operand_a);
    end
`ifdef VFPU_BRIDGE_STAT_EN
    n_vec++;
    if (drop_cnt !== 16'd1 || ops_in_cnt !== 16'd8) begin
      n_miss++;
      $display("FAIL ovf_stats: drop=%0d in=%0d, required 1 8", drop_cnt, ops_in_cnt);
    end
`endif
    drain(100);
    n_vec++;
    if (issued !== DEPTH || ovf_err !== 1'b1) begin
      n_miss++;
      $display("FAIL ovf_issue_count: issued=%0d ovf_err=%b, required 8 1", issued, ovf_err);
    end
  endtask

  task automatic test_credit;
    do_reset();
    for (int i = 0; i < 6; i++)
      push_op(32'h5000 + i, $urandom, $urandom, 1'b1);
    bus.core_op_rdy = 1'b1;
    idle(8);
    n_vec++;
    if (issued !== MAX_OUT || bus.core_op_vld !== 1'b0 || busy !== 1'b1) begin
      n_miss++;
      $display("FAIL credit_limit: issued=%0d core_op_vld=%b busy=%b, required 4 0 1",
               issued, bus.core_op_vld, busy);
    end
    core_result(32'h5555_0001);
    n_vec++;
    if (bus.core_op_vld !== 1'b1) begin
      n_miss++;
      $display("FAIL credit_release: core_op_vld=%b after result, required 1", bus.core_op_vld);
    end
    idle(1);
    n_vec++;
    if (issued !== 5 || bus.core_op_vld !== 1'b0) begin
      n_miss++;
      $display("FAIL credit_refill: issued=%0d core_op_vld=%b, required 5 0", issued, bus.core_op_vld);
    end
    for (int i = 0; i < 5; i++) begin
      core_result(32'h6600_0000 + i);
      n_vec++;
      if (bus.res_rdy !== 1'b1) begin
        n_miss++;
        $display("FAIL back_to_back_res: res_rdy=%b on result %0d, required 1", bus.res_rdy, i);
      end
    end
    idle(2);
    n_vec++;
    if (issued !== 6 || exp_q.size() != 0 || exp_res_q.size() != 0 || busy !== 1'b0 || proto_err !== 1'b0) begin
      n_miss++;
      $display("FAIL credit_drain: issued=%0d pend=%0d res_pend=%0d busy=%b proto=%b, required 6 0 0 0 0",
               issued, exp_q.size(), exp_res_q.size(), busy, proto_err);
    end
  endtask

  task automatic test_simultaneous;
    do_reset();
    for (int i = 0; i < DEPTH; i++)
      push_op(32'h7000 + i, 32'h7100 + i, 32'h7200 + i, 1'b1);
    bus.core_op_rdy = 1'b1;
    push_op(32'h7008, 32'h7108, 32'h7208, 1'b1);
    bus.core_op_rdy = 1'b0;
    n_vec++;
    if (ovf_err !== 1'b0 || issued !== 1) begin
      n_miss++;
      $display("FAIL full_push_pop: ovf_err=%b issued=%0d, required 0 1", ovf_err, issued);
    end
    bus.core_op_rdy = 1'b1;
    core_result(32'h7777_0000);
    idle(6);
    n_vec++;
    if (issued !== 5 || bus.core_op_vld !== 1'b0) begin
      n_miss++;
      $display("FAIL issue_and_result: issued=%0d core_op_vld=%b, required 5 0", issued, bus.core_op_vld);
    end
    drain(100);
    n_vec++;
    if (issued !== DEPTH + 1 || ovf_err !== 1'b0) begin
      n_miss++;
      $display("FAIL simul_total: issued=%0d ovf_err=%b, required 9 0", issued, ovf_err);
    end
  endtask

  task automatic test_proto_and_reset;
    do_reset();
    core_result(32'hDEAD_BEEF);
    n_vec++;
    if (proto_err !== 1'b1 || bus.res_rdy !== 1'b1 || bus.res !== 32'hDEAD_BEEF) begin
      n_miss++;
      $display("FAIL proto_err: proto=%b res_rdy=%b res=%h, required 1 1 deadbeef",
               proto_err, bus.res_rdy, bus.res);
    end
    for (int i = 0; i < 3; i++)
      push_op(32'h9000 + i, 32'h9100 + i, 32'h9200 + i, 1'b1);
    bus.core_op_rdy = 1'b1;
    idle(1);
    bus.op_vld = 1'b1;
    #2;
    rst = 1'b1;
    clear_inputs();
    exp_q.delete();
    exp_res_q.delete();
    issued   = 0;
    returned = 0;
    #1;
    n_vec++;
    if ({bus.res, bus.res_rdy, bus.core_op_vld, proto_err, ovf_err, busy} !== '0) begin
      n_miss++;
      $display("FAIL async_reset: res=%h res_rdy=%b vld=%b proto=%b ovf=%b busy=%b, required all 0",
               bus.res, bus.res_rdy, bus.core_op_vld, proto_err, ovf_err, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    bus.core_op_rdy = 1'b1;
    idle(2);
    n_vec++;
    if (bus.core_op_vld !== 1'b0 || busy !== 1'b0 || issued !== 0) begin
      n_miss++;
      $display("FAIL reset_discard: vld=%b busy=%b issued=%0d, required 0 0 0",
               bus.core_op_vld, busy, issued);
    end
    core_result(32'h1234_5678);
    n_vec++;
    if (proto_err !== 1'b1 || bus.res !== 32'h1234_5678) begin
      n_miss++;
      $display("FAIL post_reset_proto: proto=%b res=%h, required 1 12345678", proto_err, bus.res);
    end
    idle(2);
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_op();
    test_overflow();
    test_credit();
    test_simultaneous();
    test_proto_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
